mac_vector_unit: RTL and testbench

Parametrised, multi-lane signed fixed-point multiply-accumulate engine for the digit-recognition datapath. It computes LANES independent dot products of programmable length, covering 5x5 conv windows (len=25) and fully-connected rows (len=192). Each result is rounded, rescaled, optionally rectified (ReLU) and saturated before being handed downstream. Input and output use valid/ready handshakes so the engine can stall against weight/feature memories and the result writer.

---
 rtl/mac_vector_unit.sv | 199 +++++++++++++++++++
 tb/tb_mac_vector_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_vector_unit.sv
// Multi-lane signed fixed-point multiply-accumulate engine.
// Rounds, rescales, optionally rectifies and saturates each lane's dot product.
module mac_vector_unit #(
    parameter int DATA_W    = 16,
    parameter int LANES     = 4,
    parameter int LEN_W     = 8,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [LEN_W-1:0]         len,
    input  logic                     relu_en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*DATA_W-1:0]  a,
    input  logic [LANES*DATA_W-1:0]  b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*OUT_W-1:0]   out_data,
    output logic [LANES-1:0]         out_sat
);

    localparam int PW = 2 * DATA_W;
    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'((2**FRAC_BITS) / 2);
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    typedef enum logic [1:0] {
        ACC,
        DRAIN1,
        DRAIN2,
        OUT
    } state_t;

    state_t state, state_nx;

    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;
    logic             relu_q;
    logic             accept;
    logic             last;
    logic             prod_v;

    logic signed [PW-1:0]    mul  [LANES];
    logic signed [PW-1:0]    prod [LANES];
    logic signed [ACC_W-1:0] acc  [LANES];
    logic signed [ACC_W:0]   rsum [LANES];
    logic signed [ACC_W:0]   rsh  [LANES];
    logic [OUT_W-1:0]        res  [LANES];
    logic [LANES-1:0]        res_sat;

    logic [LANES*OUT_W-1:0]  data_q;
    logic [LANES-1:0]        sat_q;

    assign out_data = data_q;
    assign out_sat  = sat_q;
    assign accept   = in_valid && in_ready;

    // First beat of a dot uses the live length (0 counts as 1); later beats use the latched one.
    always_comb begin
        len_eff = len_q;
        if (count == '0) begin
            len_eff = (len == '0) ? LEN_W'(1) : len;
        end
    end

    assign last = accept && (count == len_eff - LEN_W'(1));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACC;
        end else if (clear) begin
            state <= ACC;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACC: begin
                in_ready = 1'b1;
                if (last) begin
                    state_nx = DRAIN1;
                end
            end
            DRAIN1: state_nx = DRAIN2;
            DRAIN2: state_nx = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = ACC;
                end
            end
            default: state_nx = ACC;
        endcase
    end

    // Beat counter plus per-dot length and ReLU mode latched on the first beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            len_q  <= '0;
            relu_q <= 1'b0;
        end else if (clear) begin
            count  <= '0;
            len_q  <= '0;
            relu_q <= 1'b0;
        end else if (accept) begin
            count <= last ? '0 : count + LEN_W'(1);
            if (count == '0) begin
                len_q  <= len_eff;
                relu_q <= relu_en;
            end
        end
    end

    // Full-width signed lane products from sign-extended operands.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mul[i] = $signed({{DATA_W{a[i*DATA_W+DATA_W-1]}}, a[i*DATA_W +: DATA_W]})
                   * $signed({{DATA_W{b[i*DATA_W+DATA_W-1]}}, b[i*DATA_W +: DATA_W]});
        end
    end

    // Product pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prod_v <= 1'b0;
            for (int i = 0; i < LANES; i++) prod[i] <= '0;
        end else if (clear) begin
            prod_v <= 1'b0;
            for (int i = 0; i < LANES; i++) prod[i] <= '0;
        end else begin
            prod_v <= accept;
            if (accept) begin
                for (int i = 0; i < LANES; i++) prod[i] <= mul[i];
            end
        end
    end

    // Wrapping accumulators; cleared once the result has been taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else if (state == OUT && out_ready) begin
            for (int i = 0; i < LANES; i++) acc[i] <= '0;
        end else if (prod_v) begin
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= acc[i] + $signed({{(ACC_W-PW){prod[i][PW-1]}}, prod[i]});
            end
        end
    end

    // Round half up, rescale, rectify, then saturate to the output width.
    always_comb begin
        res_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            rsum[i] = $signed({acc[i][ACC_W-1], acc[i]}) + RND;
            rsh[i]  = rsum[i] >>> FRAC_BITS;
            res[i]  = rsh[i][OUT_W-1:0];
            if (relu_q && rsh[i] < 0) begin
                res[i] = '0;
            end else if (rsh[i] > MAXV) begin
                res[i]     = MAXV[OUT_W-1:0];
                res_sat[i] = 1'b1;
            end else if (rsh[i] < MINV) begin
                res[i]     = MINV[OUT_W-1:0];
                res_sat[i] = 1'b1;
            end
        end
    end

    // Result register, loaded as the final sum settles and held until taken.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            sat_q  <= '0;
        end else if (clear) begin
            data_q <= '0;
            sat_q  <= '0;
        end else if (state == DRAIN2) begin
            for (int i = 0; i < LANES; i++) data_q[i*OUT_W +: OUT_W] <= res[i];
            sat_q <= res_sat;
        end
    end

endmodule

// File: tb/tb_mac_vector_unit.sv
// Bench for mac_vector_unit: fixed vector table, corner sequences,
// and randomized dots checked against an arithmetic reference model.
module tb_mac_vector_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        relu_en = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [3:0]  out_sat;

    int nvec = 0;
    int nerr = 0;

    logic [63:0] exp_d;
    logic [3:0]  exp_s;

    typedef struct {
        int          ln;
        bit          relu;
        logic [63:0] va;
        logic [63:0] vb;
        logic [63:0] eo;
        logic [3:0]  es;
    } vec_t;

    vec_t tbl[6];

    mac_vector_unit dut (
        .clk(clk), .reset(reset), .clear(clear), .len(len),
        .relu_en(relu_en), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pk(input int l0, input int l1,
                                       input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // floor((s + 2^7) / 2^8), optional ReLU, clamp to int16
    task automatic model(input longint s, input bit relu,
                         output logic [15:0] o, output bit sat);
        longint t, r;
        t = s + 128;
        r = t / 256;
        if (t < 0 && (t % 256) != 0) r = r - 1;
        sat = 1'b0;
        if (relu && r < 0) r = 0;
        if (r > 32767) begin
            r = 32767; sat = 1'b1;
        end else if (r < -32768) begin
            r = -32768; sat = 1'b1;
        end
        o = 16'(r);
    endtask

    task automatic do_dot(input int lenv, input bit relu, input bit rnd,
                          input logic [63:0] ca, input logic [63:0] cb,
                          input int gap);
        int n, got, guard;
        longint s[4];
        logic [63:0] av, bv;
        logic [15:0] o;
        bit st;
        n = (lenv == 0) ? 1 : lenv;
        got = 0;
        guard = 0;
        for (int i = 0; i < 4; i++) s[i] = 0;
        while (got < n) begin
            @(negedge clk);
            av = rnd ? {$urandom, $urandom} : ca;
            bv = rnd ? {$urandom, $urandom} : cb;
            a = av;
            b = bv;
            in_valid = ($urandom_range(0, 99) >= gap);
            len = (got == 0) ? 8'(lenv) : 8'($urandom);
            relu_en = (got == 0) ? relu : 1'($urandom);
            #1;
            if (in_valid && in_ready) begin
                for (int i = 0; i < 4; i++) begin
                    s[i] += longint'($signed(av[16*i +: 16]))
                          * longint'($signed(bv[16*i +: 16]));
                end
                got++;
            end
            @(posedge clk);
            guard++;
            if (guard > 3000) begin
                chk("feed_timeout", 64'(got), 64'(n));
                break;
            end
        end
        for (int i = 0; i < 4; i++) begin
            model(s[i], relu, o, st);
            exp_d[16*i +: 16] = o;
            exp_s[i] = st;
        end
    endtask

    task automatic wait_out(output bit ok);
        int k;
        k = 0;
        ok = 1'b0;
        while (k < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            k++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("latency", 64'(k), 64'd3);
    endtask

    task automatic collect(input int hold, output logic [63:0] gd,
                           output logic [3:0] gs);
        bit ok;
        wait_out(ok);
        gd = out_data;
        gs = out_sat;
        if (!ok) return;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_data", out_data, exp_d);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] gd;
        logic [3:0]  gs;
        bit ok;

        tbl[0] = '{25, 1'b0, pk(256, 256, 256, 256), pk(256, -256, 256, -256),
                   pk(6400, -6400, 6400, -6400), 4'h0};
        tbl[1] = '{192, 1'b0, pk(32767, 32767, 32767, 32767),
                   pk(32767, 32767, 32767, 32767),
                   pk(32767, 32767, 32767, 32767), 4'hf};
        tbl[2] = '{192, 1'b0, pk(32767, 32767, 32767, 32767),
                   pk(-32768, -32768, -32768, -32768),
                   pk(-32768, -32768, -32768, -32768), 4'hf};
        tbl[3] = '{1, 1'b0, pk(384, -384, 383, -128), pk(1, 1, 1, 1),
                   pk(2, -1, 1, 0), 4'h0};
        tbl[4] = '{25, 1'b1, pk(256, 256, 32767, 0), pk(-256, 256, -32768, 5),
                   pk(0, 6400, 0, 0), 4'h0};
        tbl[5] = '{0, 1'b0, pk(256, -256, 1000, -1000), pk(256, 256, 1000, 1000),
                   pk(256, -256, 3906, -3906), 4'h0};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_sat", 64'(out_sat), 64'd0);
        reset = 1'b0;

        foreach (tbl[v]) begin
            do_dot(tbl[v].ln, tbl[v].relu, 1'b0, tbl[v].va, tbl[v].vb, 0);
            collect(0, gd, gs);
            chk($sformatf("tbl%0d_data", v), gd, tbl[v].eo);
            chk($sformatf("tbl%0d_sat", v), 64'(gs), 64'(tbl[v].es));
        end

        // Hold result under backpressure, then abort it with clear.
        do_dot(25, 1'b0, 1'b0, tbl[0].va, tbl[0].vb, 40);
        wait_out(ok);
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            chk("bp_data", out_data, tbl[0].eo);
            chk("bp_ready", 64'(in_ready), 64'd0);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_data", out_data, 64'd0);
        chk("clr_ready", 64'(in_ready), 64'd1);
        do_dot(1, 1'b0, 1'b0, tbl[3].va, tbl[3].vb, 0);
        collect(0, gd, gs);
        chk("post_clr_data", gd, tbl[3].eo);

        // Reset mid-accumulation after 10 of 25 beats.
        len = 8'd25;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = pk(256, 256, 256, 256);
            b = pk(256, 256, 256, 256);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("amid_in_ready", 64'(in_ready), 64'd1);
        chk("amid_out_valid", 64'(out_valid), 64'd0);
        chk("amid_out_data", out_data, 64'd0);
        chk("amid_out_sat", 64'(out_sat), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        do_dot(25, 1'b0, 1'b0, pk(256, 256, 256, 256), pk(256, 256, 256, 256), 0);
        collect(0, gd, gs);
        chk("amid_dot_data", gd, pk(6400, 6400, 6400, 6400));
        chk("amid_dot_sat", 64'(gs), 64'd0);

        // Randomized dots against the reference model.
        for (int t = 0; t < 40; t++) begin
            do_dot($urandom_range(0, 30), 1'($urandom), 1'b1, '0, '0, 30);
            collect($urandom_range(0, 3), gd, gs);
            chk($sformatf("rnd%0d_data", t), gd, exp_d);
            chk($sformatf("rnd%0d_sat", t), 64'(gs), 64'(exp_s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
